// File: rtl/raw_data_decode_fsm_pkg.sv
// Shared constants for the raw-data encode/decode FSM pair: one-hot state
// encoding and lane geometry.
package raw_data_decode_fsm_pkg;

    localparam int NUM_LANES  = 4;
    localparam int LANE_IDX_W = 2;

    typedef enum logic [2:0] {
        ST_INIT    = 3'b001,
        ST_COLLECT = 3'b010,
        ST_PUSH    = 3'b100
    } state_t;

endpackage

// File: rtl/raw_data_decode_fsm.sv
// Pops four encoded lane words (lane 0 first) from a FWFT input FIFO,
// reassembles them into one raw word and pushes it to the raw output FIFO.
module raw_data_decode_fsm
    import raw_data_decode_fsm_pkg::*;
#(
    parameter int LANE_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enc_fifo_empty,
    input  logic [LANE_W-1:0]           enc_fifo_dout,
    output logic                        enc_fifo_pop,
    input  logic                        raw_out_fifo_full,
    output logic                        raw_out_fifo_push,
    output logic [NUM_LANES*LANE_W-1:0] raw_out_fifo_din,
    output logic                        raw_out_fifo_clr,
    input  logic                        flush,
    output logic [LANE_IDX_W-1:0]       lane_sel,
    output logic                        busy,
    output logic [CNT_W-1:0]            word_count
);

    state_t                        state;
    state_t                        next_state;
    logic [LANE_IDX_W-1:0]         lane_idx;
    logic [NUM_LANES*LANE_W-1:0]   assembly;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_INIT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = ST_INIT;
        case (state)
            ST_INIT:    next_state = ST_COLLECT;
            ST_COLLECT: begin
                if (!flush && !enc_fifo_empty && (lane_idx == LANE_IDX_W'(NUM_LANES - 1)))
                    next_state = ST_PUSH;
                else
                    next_state = ST_COLLECT;
            end
            ST_PUSH: begin
                if (flush || !raw_out_fifo_full)
                    next_state = ST_COLLECT;
                else
                    next_state = ST_PUSH;
            end
            default:    next_state = ST_INIT;
        endcase
    end

    // Pop and push live in disjoint states, so they can never coincide.
    always_comb begin
        enc_fifo_pop      = 1'b0;
        raw_out_fifo_push = 1'b0;
        raw_out_fifo_clr  = 1'b0;
        busy              = 1'b0;
        case (state)
            ST_INIT:    raw_out_fifo_clr = 1'b1;
            ST_COLLECT: begin
                enc_fifo_pop = !flush && !enc_fifo_empty;
                busy         = (lane_idx != '0);
            end
            ST_PUSH: begin
                raw_out_fifo_push = !flush && !raw_out_fifo_full;
                busy              = 1'b1;
            end
            default:    ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lane_idx   <= '0;
            assembly   <= '0;
            word_count <= '0;
        end else begin
            case (state)
                ST_COLLECT: begin
                    if (flush) begin
                        lane_idx <= '0;
                        assembly <= '0;
                    end else if (enc_fifo_pop) begin
                        assembly[int'(lane_idx)*LANE_W +: LANE_W] <= enc_fifo_dout;
                        // Two-bit index wraps 3 -> 0 as the word completes.
                        lane_idx <= lane_idx + LANE_IDX_W'(1);
                    end
                end
                ST_PUSH: begin
                    if (flush)
                        assembly <= '0;
                    else if (raw_out_fifo_push)
                        word_count <= sat_inc(word_count);
                end
                default:    lane_idx <= '0;
            endcase
        end
    end

    assign raw_out_fifo_din = assembly;
    assign lane_sel         = lane_idx;

endmodule

// File: tb/tb_raw_data_decode_fsm.sv
// Bench for raw_data_decode_fsm: a FWFT input FIFO model feeds lane words,
// expected raw words are queued at stimulus time and compared when pushed.
module tb_raw_data_decode_fsm;

    logic         clk = 1'b0;
    logic         reset;
    logic         enc_fifo_empty;
    logic [31:0]  enc_fifo_dout;
    logic         enc_fifo_pop;
    logic         raw_out_fifo_full;
    logic         raw_out_fifo_push;
    logic [127:0] raw_out_fifo_din;
    logic         raw_out_fifo_clr;
    logic         flush;
    logic [1:0]   lane_sel;
    logic         busy;
    logic [15:0]  word_count;

    logic         b_empty;
    logic [31:0]  b_dout;
    logic         b_pop, b_push, b_clr, b_busy;
    logic [127:0] b_din;
    logic [1:0]   b_lane_sel;
    logic [3:0]   b_word_count;

    raw_data_decode_fsm dut (
        .clk(clk), .reset(reset),
        .enc_fifo_empty(enc_fifo_empty), .enc_fifo_dout(enc_fifo_dout), .enc_fifo_pop(enc_fifo_pop),
        .raw_out_fifo_full(raw_out_fifo_full), .raw_out_fifo_push(raw_out_fifo_push),
        .raw_out_fifo_din(raw_out_fifo_din), .raw_out_fifo_clr(raw_out_fifo_clr),
        .flush(flush), .lane_sel(lane_sel), .busy(busy), .word_count(word_count)
    );

    raw_data_decode_fsm #(.LANE_W(32), .CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset),
        .enc_fifo_empty(b_empty), .enc_fifo_dout(b_dout), .enc_fifo_pop(b_pop),
        .raw_out_fifo_full(1'b0), .raw_out_fifo_push(b_push),
        .raw_out_fifo_din(b_din), .raw_out_fifo_clr(b_clr),
        .flush(1'b0), .lane_sel(b_lane_sel), .busy(b_busy), .word_count(b_word_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int exp_count = 0;

    logic [31:0]  in_q[$];
    logic [127:0] exp_q[$];
    logic [127:0] got_q[$];
    logic         full_f;

    logic         last_pop, last_push, last_clr, last_busy, last_b_push;
    logic [1:0]   last_lane_sel;
    logic [127:0] last_din;

    function automatic logic [127:0] make_word(input logic [31:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic drive();
        enc_fifo_empty    = (in_q.size() == 0);
        enc_fifo_dout     = (in_q.size() != 0) ? in_q[0] : 32'h0;
        raw_out_fifo_full = full_f;
    endtask

    task automatic step();
        drive();
        @(negedge clk);
        last_pop      = enc_fifo_pop;
        last_push     = raw_out_fifo_push;
        last_clr      = raw_out_fifo_clr;
        last_busy     = busy;
        last_lane_sel = lane_sel;
        last_din      = raw_out_fifo_din;
        last_b_push   = b_push;
        @(posedge clk);
        #1;
        if (last_pop && in_q.size() != 0) void'(in_q.pop_front());
        if (last_push) got_q.push_back(last_din);
        drive();
    endtask

    task automatic feed_word(input logic [31:0] l0, l1, l2, l3, input bit expect_out);
        in_q.push_back(l0); in_q.push_back(l1); in_q.push_back(l2); in_q.push_back(l3);
        if (expect_out) begin
            exp_q.push_back(make_word(l0, l1, l2, l3));
            exp_count++;
        end
    endtask

    task automatic run_until_push(input int budget, input string name);
        int n = 0;
        do begin
            step();
            n++;
        end while (!last_push && n < budget);
        checks++;
        if (!last_push) begin
            failures++;
            $display("FAIL %s: push not seen within %0d cycles", name, budget);
        end
    endtask

    task automatic compare_words(input string name);
        while (exp_q.size() != 0) begin
            logic [127:0] e;
            e = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) begin
                failures++;
                $display("FAIL %s: missing word, expected %h", name, e);
            end else begin
                logic [127:0] g;
                g = got_q.pop_front();
                if (g !== e) begin
                    failures++;
                    $display("FAIL %s: din got %h expected %h", name, g, e);
                end
            end
        end
        checks++;
        if (got_q.size() != 0) begin
            failures++;
            $display("FAIL %s: %0d unexpected pushed words", name, got_q.size());
            got_q.delete();
        end
        checks++;
        if (word_count !== 16'(exp_count)) begin
            failures++;
            $display("FAIL %s: word_count got %0d expected %0d", name, word_count, exp_count);
        end
    endtask

    task automatic test_reset();
        int clr_cycles = 0;
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        step();
        checks++;
        if ({last_clr, last_pop, last_push, last_busy, last_lane_sel} !== 6'b100000) begin
            failures++;
            $display("FAIL reset_init: clr/pop/push/busy/lane_sel got %b expected 100000",
                     {last_clr, last_pop, last_push, last_busy, last_lane_sel});
        end
        checks++;
        if (word_count !== 16'd0 || b_word_count !== 4'd0) begin
            failures++;
            $display("FAIL reset_count: word_count got %0d/%0d expected 0", word_count, b_word_count);
        end
        clr_cycles = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (last_clr) clr_cycles++;
        end
        checks++;
        if (clr_cycles != 1) begin
            failures++;
            $display("FAIL reset_clr_pulse: clr cycles got %0d expected 1", clr_cycles);
        end
    endtask

    task automatic test_basic();
        feed_word(32'h11, 32'h22, 32'h33, 32'h44, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (last_pop !== (i < 4) || last_push !== (i == 4)) begin
                failures++;
                $display("FAIL basic_timing cycle %0d: pop=%b push=%b expected pop=%b push=%b",
                         i, last_pop, last_push, i < 4, i == 4);
            end
        end
        compare_words("basic");
    endtask

    task automatic test_empty_stall();
        in_q.push_back(32'hA0); in_q.push_back(32'hA1);
        step(); step();
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (last_lane_sel !== 2'd2 || last_busy !== 1'b1 || last_pop !== 1'b0) begin
                failures++;
                $display("FAIL empty_stall cycle %0d: lane_sel=%0d busy=%b pop=%b expected 2 1 0",
                         i, last_lane_sel, last_busy, last_pop);
            end
        end
        in_q.push_back(32'hA2); in_q.push_back(32'hA3);
        exp_q.push_back(make_word(32'hA0, 32'hA1, 32'hA2, 32'hA3));
        exp_count++;
        run_until_push(10, "empty_stall");
        compare_words("empty_stall");
    endtask

    task automatic test_full_stall();
        full_f = 1'b1;
        feed_word(32'hC0, 32'hC1, 32'hC2, 32'hC3, 1'b1);
        feed_word(32'hD0, 32'hD1, 32'hD2, 32'hD3, 1'b1);
        for (int i = 0; i < 4; i++) step();
        for (int i = 0; i < 7; i++) begin
            step();
            checks++;
            if (last_push !== 1'b0 || last_pop !== 1'b0 || last_busy !== 1'b1) begin
                failures++;
                $display("FAIL full_stall cycle %0d: push=%b pop=%b busy=%b expected 0 0 1",
                         i, last_push, last_pop, last_busy);
            end
        end
        full_f = 1'b0;
        step();
        checks++;
        if (last_push !== 1'b1) begin
            failures++;
            $display("FAIL full_release: push got %b expected 1", last_push);
        end
        run_until_push(10, "full_second");
        compare_words("full_stall");
    endtask

    task automatic test_flush();
        in_q.push_back(32'hAA); in_q.push_back(32'hBB);
        step(); step();
        feed_word(32'h1, 32'h2, 32'h3, 32'h4, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if (last_pop !== 1'b0 || lane_sel !== 2'd0) begin
            failures++;
            $display("FAIL flush_collect: pop=%b lane_sel=%0d expected 0 0", last_pop, lane_sel);
        end
        run_until_push(10, "flush_collect");
        compare_words("flush_collect");
        // Flush while a complete word waits in PUSH: word must be dropped.
        feed_word(32'h5, 32'h6, 32'h7, 32'h8, 1'b0);
        for (int i = 0; i < 4; i++) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if (last_push !== 1'b0 || last_busy !== 1'b1) begin
            failures++;
            $display("FAIL flush_push: push=%b busy=%b expected 0 1", last_push, last_busy);
        end
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (busy !== 1'b0 || lane_sel !== 2'd0) begin
            failures++;
            $display("FAIL flush_push_idle: busy=%b lane_sel=%0d expected 0 0", busy, lane_sel);
        end
        compare_words("flush_push");
    endtask

    task automatic test_reset_mid_word();
        in_q.push_back(32'hE0); in_q.push_back(32'hE1);
        step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_count = 0;
        step();
        checks++;
        if (last_clr !== 1'b1 || last_lane_sel !== 2'd0 || last_busy !== 1'b0 || word_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_mid: clr=%b lane_sel=%0d busy=%b count=%0d expected 1 0 0 0",
                     last_clr, last_lane_sel, last_busy, word_count);
        end
        feed_word(32'hF0, 32'hF1, 32'hF2, 32'hF3, 1'b1);
        run_until_push(10, "reset_mid");
        compare_words("reset_mid");
    endtask

    task automatic test_saturation();
        int n = 0;
        int cyc = 0;
        b_empty = 1'b0;
        while (n < 18 && cyc < 300) begin
            step();
            cyc++;
            if (last_b_push) begin
                n++;
                checks++;
                if (b_word_count !== 4'((n > 15) ? 15 : n)) begin
                    failures++;
                    $display("FAIL saturation push %0d: word_count got %0d expected %0d",
                             n, b_word_count, (n > 15) ? 15 : n);
                end
            end
        end
        b_empty = 1'b1;
        checks++;
        if (n < 18) begin
            failures++;
            $display("FAIL saturation: only %0d pushes seen, expected 18", n);
        end
    endtask

    initial begin
        reset   = 1'b1;
        flush   = 1'b0;
        full_f  = 1'b0;
        b_empty = 1'b1;
        b_dout  = 32'h5;
        drive();
        test_reset();
        test_basic();
        test_empty_stall();
        test_full_stall();
        test_flush();
        test_reset_mid_word();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
